// File: rtl/dense_accumulator.sv
// Dense-layer output stage: multiply-accumulates (activation, weight) pairs into
// one wrapping unsigned sum per neuron and emits (index, value, enable) beats for argmax.
module dense_accumulator #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned INPUT_AMOUNT  = 2,
  parameter int unsigned NEURON_AMOUNT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] input_value,
  input  logic [DATA_WIDTH-1:0] input_weight,
  input  logic                  input_enable,
  input  logic                  input_clear,
  output logic [DATA_WIDTH-1:0] output_index,
  output logic [DATA_WIDTH-1:0] output_value,
  output logic                  output_enable,
  output logic                  output_last
);

  localparam int unsigned BW = (INPUT_AMOUNT  > 1) ? $clog2(INPUT_AMOUNT)  : 1;
  localparam int unsigned NW = (NEURON_AMOUNT > 1) ? $clog2(NEURON_AMOUNT) : 1;
  localparam logic [BW-1:0] BEAT_LAST   = BW'(INPUT_AMOUNT - 1);
  localparam logic [NW-1:0] NEURON_LAST = NW'(NEURON_AMOUNT - 1);

  logic [DATA_WIDTH-1:0] acc;
  logic [BW-1:0]         beat_cnt;
  logic [NW-1:0]         neuron_cnt;
  logic [DATA_WIDTH-1:0] product;
  logic [DATA_WIDTH-1:0] sum;

  // Self-determined multiply inside the cast keeps only the low DATA_WIDTH bits.
  always_comb begin
    product = DATA_WIDTH'(input_value * input_weight);
    sum     = acc + product;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc           <= '0;
      beat_cnt      <= '0;
      neuron_cnt    <= '0;
      output_index  <= '0;
      output_value  <= '0;
      output_enable <= 1'b0;
      output_last   <= 1'b0;
    end else begin
      output_enable <= 1'b0;
      output_last   <= 1'b0;
      if (input_clear) begin
        // Restart the current neuron; its index is kept so it is not skipped.
        acc      <= '0;
        beat_cnt <= '0;
      end else if (input_enable) begin
        if (beat_cnt == BEAT_LAST) begin
          output_value  <= sum;
          output_index  <= DATA_WIDTH'(neuron_cnt);
          output_enable <= 1'b1;
          output_last   <= (neuron_cnt == NEURON_LAST);
          acc           <= '0;
          beat_cnt      <= '0;
          if (neuron_cnt == NEURON_LAST) neuron_cnt <= '0;
          else                           neuron_cnt <= neuron_cnt + NW'(1);
        end else begin
          acc      <= sum;
          beat_cnt <= beat_cnt + BW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dense_accumulator.sv
// Scoreboard bench for dense_accumulator: directed scenarios plus random pairs,
// checked against a queue-based reference model of per-neuron dot products.
module tb_dense_accumulator;

  localparam int unsigned DW = 32;
  localparam int unsigned IA = 2;
  localparam int unsigned NA = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] input_value;
  logic [DW-1:0] input_weight;
  logic          input_enable;
  logic          input_clear;
  logic [DW-1:0] output_index;
  logic [DW-1:0] output_value;
  logic          output_enable;
  logic          output_last;

  dense_accumulator #(
    .DATA_WIDTH(DW),
    .INPUT_AMOUNT(IA),
    .NEURON_AMOUNT(NA)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .input_value(input_value),
    .input_weight(input_weight),
    .input_enable(input_enable),
    .input_clear(input_clear),
    .output_index(output_index),
    .output_value(output_value),
    .output_enable(output_enable),
    .output_last(output_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] idx;
    logic [DW-1:0] val;
    logic          last;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] pend[$];
  int          next_neuron = 0;
  int          total = 0;
  int          bad = 0;
  int          rst_count = 0;
  bit          mon_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: collect full-width products, emit their sum once a neuron is complete.
  task automatic model_step(input logic [DW-1:0] v, input logic [DW-1:0] w,
                            input logic en, input logic clr);
    logic [63:0] s;
    exp_t        e;
    if (clr) begin
      pend.delete();
    end else if (en) begin
      pend.push_back({32'b0, v} * {32'b0, w});
      if (pend.size() == IA) begin
        s = 64'd0;
        foreach (pend[i]) s = s + pend[i];
        e.idx  = DW'(next_neuron);
        e.val  = s[DW-1:0];
        e.last = (next_neuron == NA - 1);
        sb.push_back(e);
        next_neuron = (next_neuron + 1) % NA;
        pend.delete();
      end
    end
  endtask

  task automatic drive(input logic [DW-1:0] v, input logic [DW-1:0] w,
                       input logic en, input logic clr);
    @(negedge clk);
    input_value  = v;
    input_weight = w;
    input_enable = en;
    input_clear  = clr;
    model_step(v, w, en, clr);
  endtask

  task automatic expect_pulse(input string name, input logic [DW-1:0] idx,
                              input logic [DW-1:0] val, input logic last);
    @(posedge clk);
    #1;
    check({name, "_en"},   64'(output_enable), 64'd1);
    check({name, "_idx"},  64'(output_index),  64'(idx));
    check({name, "_val"},  64'(output_value),  64'(val));
    check({name, "_last"}, 64'(output_last),   64'(last));
    input_enable = 1'b0;
    input_clear  = 1'b0;
  endtask

  task automatic check_zero(input string name);
    check({name, "_en"},   64'(output_enable), 64'd0);
    check({name, "_idx"},  64'(output_index),  64'd0);
    check({name, "_val"},  64'(output_value),  64'd0);
    check({name, "_last"}, 64'(output_last),   64'd0);
  endtask

  task automatic pulse_reset(input string name);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    pend.delete();
    sb.delete();
    next_neuron = 0;
    rst_count++;
    #1;
    check_zero(name);
    @(negedge clk);
    input_enable = 1'b0;
    input_clear  = 1'b0;
    rst_n = 1'b1;
  endtask

  // Monitor: every pulse must match the head of the scoreboard; between pulses
  // index/value must hold the last emitted beat.
  initial begin
    exp_t          e;
    logic [DW-1:0] held_idx = '0;
    logic [DW-1:0] held_val = '0;
    int            seen = 0;
    wait (mon_on);
    forever begin
      @(posedge clk);
      #1;
      if (rst_count != seen) begin
        seen = rst_count;
        held_idx = '0;
        held_val = '0;
      end
      if (output_enable) begin
        if (sb.size() == 0) begin
          check("unexpected_pulse", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("mon_idx",  64'(output_index), 64'(e.idx));
          check("mon_val",  64'(output_value), 64'(e.val));
          check("mon_last", 64'(output_last),  64'(e.last));
          held_idx = e.idx;
          held_val = e.val;
        end
      end else begin
        check("missing_pulse", 64'(sb.size()), 64'd0);
        sb.delete();
        check("hold_idx",  64'(output_index), 64'(held_idx));
        check("hold_val",  64'(output_value), 64'(held_val));
        check("idle_last", 64'(output_last),  64'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          en;
    logic          clr;
    logic [DW-1:0] v;
    logic [DW-1:0] w;
    rst_n        = 1'b0;
    input_value  = '0;
    input_weight = '0;
    input_enable = 1'b0;
    input_clear  = 1'b0;

    // 1: asynchronous mid-cycle reset, then quiet outputs after release
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("reset_async");
    @(negedge clk);
    rst_n = 1'b1;
    mon_on = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_zero("reset_idle");
    end

    // 2: basic sum and hold after the pulse
    drive(32'd3, 32'd2, 1'b1, 1'b0);
    drive(32'd4, 32'd1, 1'b1, 1'b0);
    expect_pulse("basic", 32'd0, 32'd10, 1'b0);
    @(posedge clk);
    #1;
    check("basic_fall_en", 64'(output_enable), 64'd0);
    check("basic_hold_val", 64'(output_value), 64'd10);

    // 3: gap between beats, then index wrap
    drive(32'd1, 32'd5, 1'b1, 1'b0);
    drive(32'd0, 32'd0, 1'b0, 1'b0);
    drive(32'd2, 32'd2, 1'b1, 1'b0);
    expect_pulse("gap", 32'd1, 32'd9, 1'b1);
    drive(32'd1, 32'd1, 1'b1, 1'b0);
    drive(32'd1, 32'd1, 1'b1, 1'b0);
    expect_pulse("wrap", 32'd0, 32'd2, 1'b0);

    // 4: clear wins over a simultaneous beat and restarts the same neuron
    drive(32'd7, 32'd7, 1'b1, 1'b0);
    drive(32'd9, 32'd9, 1'b1, 1'b1);
    drive(32'd1, 32'd1, 1'b1, 1'b0);
    drive(32'd2, 32'd3, 1'b1, 1'b0);
    expect_pulse("clear", 32'd1, 32'd7, 1'b1);

    // 5: modular wrap and product truncation
    drive(32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0);
    drive(32'd1, 32'd1, 1'b1, 1'b0);
    expect_pulse("overflow", 32'd0, 32'd0, 1'b0);
    drive(32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0);
    drive(32'd5, 32'd1, 1'b1, 1'b0);
    expect_pulse("trunc", 32'd1, 32'd5, 1'b1);

    // 6: reset mid-neuron discards the partial sum and restarts at index 0
    drive(32'd1, 32'd1, 1'b1, 1'b0);
    drive(32'd1, 32'd1, 1'b1, 1'b0);
    expect_pulse("pre_reset", 32'd0, 32'd2, 1'b0);
    drive(32'd4, 32'd4, 1'b1, 1'b0);
    pulse_reset("reset_mid");
    drive(32'd2, 32'd2, 1'b1, 1'b0);
    drive(32'd3, 32'd3, 1'b1, 1'b0);
    expect_pulse("post_reset", 32'd0, 32'd13, 1'b0);

    // Random pairs, gaps and clears, checked only by the monitor
    for (int i = 0; i < 600; i++) begin
      en  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 1) == 0) begin
        v = DW'($urandom_range(0, 255));
        w = DW'($urandom_range(0, 255));
      end else begin
        v = $urandom;
        w = $urandom;
      end
      drive(v, w, en, clr);
    end
    drive('0, '0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dense_accumulator.md
# dense_accumulator

Fully-connected layer output stage placed directly upstream of `softmax_cell`, the argmax stage. It multiply-accumulates a stream of (activation, weight) pairs into one sum per neuron. Each completed sum is emitted as an (index, value, enable) beat whose format matches the argmax stage's `input_index`/`input_value`/`input_enable` inputs. Neuron indices run 0..NEURON_AMOUNT-1 and wrap, so one full pass equals one argmax decision.

## Interface
- DATA_WIDTH, 32, width of activations, weights, sums and index.
- INPUT_AMOUNT, 2, products accumulated per neuron (≥1).
- NEURON_AMOUNT, 2, neurons per pass; must equal the downstream WEIGHT_AMOUNT (≥1).

- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- input_value  in  DATA_WIDTH  unsigned activation.
- input_weight  in  DATA_WIDTH  unsigned weight.
- input_enable  in  1  pair valid this cycle.
- input_clear  in  1  synchronous abort of the current neuron's partial sum.
- output_index  out  DATA_WIDTH  neuron index of the emitted sum.
- output_value  out  DATA_WIDTH  emitted sum.
- output_enable  out  1  one-cycle pulse; output_index/output_value are valid while it is high.
- output_last  out  1  high together with output_enable when output_index == NEURON_AMOUNT-1.

## Operation
- Internal state:
  - `acc`, DATA_WIDTH bits.
  - `beat_cnt`, 0..INPUT_AMOUNT-1.
  - `neuron_cnt`, 0..NEURON_AMOUNT-1.
- Arithmetic is unsigned.
  - Product = low DATA_WIDTH bits of input_value*input_weight.
  - The sum wraps modulo 2^DATA_WIDTH.
  - There is no saturation or overflow flag.
- On an accepted beat (input_enable=1, input_clear=0) with beat_cnt < INPUT_AMOUNT-1:
  - acc ← acc + product.
  - beat_cnt increments.
- On an accepted beat with beat_cnt == INPUT_AMOUNT-1 (the final beat):
  - output_value ← acc + product.
  - output_index ← neuron_cnt, zero-extended.
  - output_enable ← 1.
  - output_last ← (neuron_cnt == NEURON_AMOUNT-1).
  - acc ← 0 and beat_cnt ← 0.
  - neuron_cnt increments, wrapping NEURON_AMOUNT-1 → 0.
- Cycles with input_enable=0 change nothing. Gaps between beats are allowed and do not count as beats.
- input_clear=1:
  - Sets acc ← 0 and beat_cnt ← 0.
  - Leaves neuron_cnt unchanged, so the neuron is restarted, not skipped.
  - Wins over a simultaneous input_enable, and that beat is dropped.
  - Does not cancel an output_enable already registered.
- INPUT_AMOUNT=1: every accepted beat is a final beat.
- Back-to-back final beats produce output_enable high on consecutive cycles with distinct indices.

## Timing
- Reset values: output_index=0, output_value=0, output_enable=0, output_last=0; internally acc=0, beat_cnt=0, neuron_cnt=0.
- rst_n low mid-neuron discards the partial sum. The next pass starts at index 0.
- Latency: output_enable rises on the clock edge that samples the final beat and is high for exactly one cycle.
- output_index and output_value hold their last emitted values until the next emission. They are not cleared when output_enable falls.
- All outputs are registered, with no combinational path from input to output.
- Throughput: one pair per cycle, sustained. There is no back-pressure, so the downstream stage must accept every pulse.

## Test plan
1. Reset: assert rst_n=0 asynchronously mid-cycle → all outputs 0 immediately, and they stay 0 with input_enable=0 for 3 cycles after release.
2. Basic sum: pairs (3,2) then (4,1) on consecutive cycles → one cycle later output_enable=1, output_value=10, output_index=0, output_last=0. Next cycle output_enable=0 and output_value is still 10.
3. Gaps and wrap:
   - Pairs (1,5), an idle cycle, then (2,2) → output_value=9, output_index=1, output_last=1.
   - A further (1,1),(1,1) → output_value=2, output_index=0 (wrap).
4. Clear priority: pair (7,7), then a cycle with input_clear=1 and input_enable=1 carrying (9,9), then (1,1),(2,3) → output_value=7, and the index is the same one a clean neuron would have received.
5. Overflow: pairs (0xFFFFFFFF,1),(1,1) → output_value=0, output_enable=1. Pair (0x10000,0x10000) truncates its product to 0.
6. Reset mid-operation: emit index 0, feed one beat of neuron 1, pulse rst_n=0, then feed (2,2),(3,3) → output_value=13, output_index=0.
